line_window: RTL and testbench
==============================

# line_window

Builds a 3x3 pixel neighbourhood for the median filter from the incoming video stream. It sits directly downstream of `addr_ctrl` and uses its `addr` (column index within the current line) and `width` (pixel count of the last completed line) outputs. It stores the two previous lines in on-chip line memories and emits one full 3x3 window per active pixel, with sync and data-enable delayed by the same latency, to the sorting stage.

## Interface
- `ADDR_W`, 11: column address width; must match `addr_ctrl`; line memory depth is 2**ADDR_W.
- `DATA_W`, 8: pixel component width.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `vsync`  in  1  frame sync, same cycle as `addr_ctrl` inputs.
- `hsync`  in  1  line sync.
- `de`  in  1  pixel valid.
- `pix_in`  in  DATA_W  pixel, valid when `de`=1.
- `addr`  in  ADDR_W  column index from `addr_ctrl`, aligned with `pix_in`.
- `width`  in  ADDR_W  pixels in the previous line, from `addr_ctrl`.
- `win`  out  9*DATA_W  window, packed row-major: [DATA_W-1:0] = top-left (p00), up to [9*DATA_W-1:8*DATA_W] = bottom-right (p22).
- `win_valid`  out  1  `win` is complete and usable.
- `de_o`, `hsync_o`, `vsync_o`  out  1 each  `de`/`hsync`/`vsync` delayed to align with `win`.
- `eol_o`  out  1  window at last column of the line (`addr` = `width`-1 at input).

## Operation
- Line memories: `lm0` holds line N-1, `lm1` holds line N-2. Both read at `addr` in the input cycle with synchronous read.
- Stage 1 (cycle t): register `pix_in`, `addr`, `de`, syncs. Issue reads of `lm0[addr]` and `lm1[addr]`.
- Stage 2 (cycle t+1): when `de_d1`=1, write `lm0[addr_d1]` <= `pix_d1` and `lm1[addr_d1]` <= `lm0` read data. This read-before-write is safe because `addr` never repeats on consecutive `de` cycles. Form the column {top=`lm1` rd, mid=`lm0` rd, bot=`pix_d1`}. Shift the column registers: col0<=col1, col1<=col2, col2<=new column. The shift happens only when `de_d1`=1.
- Column counter `col_cnt` is 2 bits, saturates at 3. It clears when `hsync` rises and increments per `de` pixel.
- Line counter `line_cnt` is 2 bits, saturates at 3. It clears when `vsync` rises. It increments when `hsync` rises only if the preceding line contained at least one `de` pixel.
- `win_valid` = `de_o` AND `line_cnt`>=2 AND `col_cnt`>=2, with both counters sampled for the pixel in the output slot. The window center is pixel (line-1, col-1).
- Pixels with `addr` >= 2**ADDR_W cannot occur. If `width`=0, `eol_o` stays 0.
- If `vsync` and `hsync` rise in the same cycle, both counters clear. Line memory contents are not cleared; stale data is masked by `win_valid`.

## Timing
- Latency from input to output is 2 cycles. Pixel at cycle t is p22 of the window presented at t+2. `de_o`, `hsync_o`, `vsync_o` and `eol_o` are all delayed by 2 cycles.
- Outputs are registered with no combinational input-to-output path.
- Reset values: `win`=0, `win_valid`=0, `de_o`=0, `hsync_o`=0, `vsync_o`=0, `eol_o`=0, counters=0, column registers=0. Line memories are not reset.
- Reset mid-line: outputs are 0 on the next cycle. The first valid window requires two new full lines plus 3 pixels.
- Throughput is one window per clock. There is no backpressure.

## Structure
- Shared package `median_pkg`: `DATA_W`, `WIN_N`=9, window index constants (P00..P22), packing helper.
- Sub-module `line_ram`: simple dual-port RAM with one write port and one synchronous read port, parameters `ADDR_W` and `DATA_W`, inferring block RAM. It is instantiated twice.

## Test plan
- Reset: hold `rst` for 3 cycles with random inputs -> every output is 0. Release, idle 10 cycles -> every output remains 0.
- Basic frame: `vsync` pulse, then 3 lines of width 4 with `pix_in`=16*line+col -> first `win_valid` appears 2 cycles after line 2, col 2. Check `win` = {0x22,0x21,0x20,0x12,0x11,0x10,0x02,0x01,0x00} (p22..p00). Exactly 2 valid windows appear on line 2, and `eol_o` asserts with the col-3 window.
- Empty line: `hsync` pulse with no `de` between lines 0 and 1 -> `line_cnt` is unchanged, and the windows match the basic-frame values.
- Mid-frame `vsync`: assert `vsync` during line 3 -> `win_valid` drops. The next valid window requires two new lines, and its top row contains new-frame data only.
- `de` gaps: insert idle cycles between pixels within a line -> the window shifts only on `de`, values match the gap-free run, and `win_valid` is never asserted while `de_o`=0.
- Mid-line reset: assert `rst` at line 2, col 2 for 1 cycle -> `win_valid`=0 the next cycle, with recovery as described under the reset-mid-line rule.

Source files
------------

// File: rtl/median_pkg.sv
`default_nettype none
// ============================================================================
// Module   : median_pkg
// Purpose  : Shared constants and helpers for the median-filter pipeline.
//            Defines the window geometry, the row-major index of every
//            window position (P00 = top-left .. P22 = bottom-right) and
//            small helpers used by the window builder.
// Revision : 1.0 - initial release
// ============================================================================
package median_pkg;

  localparam int DATA_W   = 8;
  localparam int WIN_SIDE = 3;
  localparam int WIN_N    = 9;

  // Row-major window positions: index = row*3 + col
  localparam int P00 = 0;
  localparam int P01 = 1;
  localparam int P02 = 2;
  localparam int P10 = 3;
  localparam int P11 = 4;
  localparam int P12 = 5;
  localparam int P20 = 6;
  localparam int P21 = 7;
  localparam int P22 = 8;

  // Slot of window element (row, col) inside the packed window vector
  function automatic int win_idx(input int row, input int col);
    return row * WIN_SIDE + col;
  endfunction

  // 2-bit counter increment that sticks at 3
  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == 2'd3) ? 2'd3 : v + 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/line_ram.sv
`default_nettype none
// ============================================================================
// Module   : line_ram
// Purpose  : Simple dual-port line memory, one write port and one
//            synchronous read port, written to map onto block RAM.
//            Contents are never reset.
// Ports    : clk      - clock
//            i_we     - write enable
//            i_waddr  - write address
//            i_wdata  - write data
//            i_raddr  - read address (data appears one cycle later)
//            o_rdata  - registered read data
// Revision : 1.0 - initial release
// ============================================================================
module line_ram
  import median_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/line_window.sv
`default_nettype none
// ============================================================================
// Module   : line_window
// Purpose  : Builds a 3x3 pixel neighbourhood from a video stream using two
//            line memories (previous line, line before that). One window per
//            active pixel, 2-cycle latency, syncs delayed to match.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            i_vsync/i_hsync/i_de - frame sync, line sync, pixel valid
//            i_pix_in             - pixel
//            i_addr               - column index of i_pix_in
//            i_width              - pixel count of the previous line
//            o_win                - window, row-major, p00 in the LSBs
//            o_win_valid          - window holds 3 real lines x 3 columns
//            o_de/o_hsync/o_vsync - delayed input controls
//            o_eol                - window is at the last column of a line
// Revision : 1.0 - initial release
// ============================================================================
module line_window
  import median_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_vsync,
  input  logic                    i_hsync,
  input  logic                    i_de,
  input  logic [DATA_W-1:0]       i_pix_in,
  input  logic [ADDR_W-1:0]       i_addr,
  input  logic [ADDR_W-1:0]       i_width,
  output logic [WIN_N*DATA_W-1:0] o_win,
  output logic                    o_win_valid,
  output logic                    o_de,
  output logic                    o_hsync,
  output logic                    o_vsync,
  output logic                    o_eol
);

  // Stage 1 registers
  logic [DATA_W-1:0] r_pix_d1;
  logic [ADDR_W-1:0] r_addr_d1;
  logic              r_de_d1, r_hs_d1, r_vs_d1, r_eol_d1, r_ok_d1;

  // Line / column bookkeeping
  logic [1:0]        r_col_cnt, r_line_cnt;
  logic              r_open;    // an hsync has started a line since reset/vsync
  logic              r_has_de;  // the open line has carried at least one pixel

  // Stage 2 (output) registers; r_col[column][row], column 2 is newest
  logic [DATA_W-1:0] r_col [3][3];
  logic              r_valid_o, r_de_o, r_hs_o, r_vs_o, r_eol_o;

  logic              w_hs_rise, w_vs_rise, w_ok, w_eol;
  logic [1:0]        w_col_base, w_line_nxt;
  logic [DATA_W-1:0] w_lm0_rd, w_lm1_rd;
  logic [WIN_N*DATA_W-1:0] w_win;

  // r_hs_d1 / r_vs_d1 double as the previous-cycle sync for edge detection
  assign w_hs_rise  = i_hsync & ~r_hs_d1;
  assign w_vs_rise  = i_vsync & ~r_vs_d1;
  assign w_col_base = w_hs_rise ? 2'd0 : r_col_cnt;
  assign w_eol      = i_de && (i_width != '0) && (i_addr == (i_width - ADDR_W'(1)));

  // Line count as seen by the pixel in this cycle
  always_comb begin
    w_line_nxt = r_line_cnt;
    if (w_vs_rise) begin
      w_line_nxt = 2'd0;
    end else if (w_hs_rise && r_has_de) begin
      w_line_nxt = sat_inc(r_line_cnt);
    end
  end

  assign w_ok = i_de && (w_line_nxt >= 2'd2) && (w_col_base >= 2'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pix_d1   <= '0;
      r_addr_d1  <= '0;
      r_de_d1    <= 1'b0;
      r_hs_d1    <= 1'b0;
      r_vs_d1    <= 1'b0;
      r_eol_d1   <= 1'b0;
      r_ok_d1    <= 1'b0;
      r_col_cnt  <= 2'd0;
      r_line_cnt <= 2'd0;
      r_open     <= 1'b0;
      r_has_de   <= 1'b0;
    end else begin
      r_pix_d1   <= i_pix_in;
      r_addr_d1  <= i_addr;
      r_de_d1    <= i_de;
      r_hs_d1    <= i_hsync;
      r_vs_d1    <= i_vsync;
      r_eol_d1   <= w_eol;
      r_ok_d1    <= w_ok;
      r_col_cnt  <= i_de ? sat_inc(w_col_base) : w_col_base;
      r_line_cnt <= w_line_nxt;
      // A line interrupted by vsync or reset must not count as a full line,
      // so pixels only mark a line as non-empty once an hsync has opened it.
      if (w_hs_rise) begin
        r_open   <= 1'b1;
        r_has_de <= i_de;
      end else if (w_vs_rise) begin
        r_open   <= 1'b0;
        r_has_de <= 1'b0;
      end else if (i_de && r_open) begin
        r_has_de <= 1'b1;
      end
    end
  end

  // lm0 holds line N-1, lm1 holds line N-2. lm1 is fed with lm0's old value
  // at the same column, read the cycle before the overwrite.
  line_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_lm0 (
    .clk     (clk),
    .i_we    (r_de_d1),
    .i_waddr (r_addr_d1),
    .i_wdata (r_pix_d1),
    .i_raddr (i_addr),
    .o_rdata (w_lm0_rd)
  );

  line_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_lm1 (
    .clk     (clk),
    .i_we    (r_de_d1),
    .i_waddr (r_addr_d1),
    .i_wdata (w_lm0_rd),
    .i_raddr (i_addr),
    .o_rdata (w_lm1_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 3; c++) begin
        for (int r = 0; r < 3; r++) begin
          r_col[c][r] <= '0;
        end
      end
      r_valid_o <= 1'b0;
      r_de_o    <= 1'b0;
      r_hs_o    <= 1'b0;
      r_vs_o    <= 1'b0;
      r_eol_o   <= 1'b0;
    end else begin
      if (r_de_d1) begin
        r_col[0]    <= r_col[1];
        r_col[1]    <= r_col[2];
        r_col[2][0] <= w_lm1_rd;
        r_col[2][1] <= w_lm0_rd;
        r_col[2][2] <= r_pix_d1;
      end
      r_valid_o <= r_ok_d1;
      r_de_o    <= r_de_d1;
      r_hs_o    <= r_hs_d1;
      r_vs_o    <= r_vs_d1;
      r_eol_o   <= r_eol_d1;
    end
  end

  always_comb begin
    w_win = '0;
    for (int c = 0; c < 3; c++) begin
      for (int r = 0; r < 3; r++) begin
        w_win[win_idx(r, c)*DATA_W +: DATA_W] = r_col[c][r];
      end
    end
  end

  assign o_win       = w_win;
  assign o_win_valid = r_valid_o;
  assign o_de        = r_de_o;
  assign o_hsync     = r_hs_o;
  assign o_vsync     = r_vs_o;
  assign o_eol       = r_eol_o;

endmodule
`default_nettype wire

// File: tb/tb_line_window.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_window
// Purpose  : Self-checking bench for line_window. A frame-level model keeps
//            an image of the lines seen since the last vsync/reset and
//            derives every expected window from it.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_line_window;

  localparam int AW = 11;
  localparam int DW = 8;
  localparam int WW = 9 * DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, vsync, hsync, de;
  logic [DW-1:0] pix;
  logic [AW-1:0] addr, width;
  logic [WW-1:0] win;
  logic          win_valid, de_o, hs_o, vs_o, eol_o;

  line_window #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_vsync     (vsync),
    .i_hsync     (hsync),
    .i_de        (de),
    .i_pix_in    (pix),
    .i_addr      (addr),
    .i_width     (width),
    .o_win       (win),
    .o_win_valid (win_valid),
    .o_de        (de_o),
    .o_hsync     (hs_o),
    .o_vsync     (vs_o),
    .o_eol       (eol_o)
  );

  typedef struct packed {
    logic          valid;
    logic          de;
    logic          hs;
    logic          vs;
    logic          eol;
    logic [WW-1:0] win;
  } rec_t;

  rec_t exp_q[$];   // expected output produced by input of tick i
  rec_t act_q[$];   // outputs sampled 1ns after the edge ending tick i
  int   rst_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Frame model
  int            m_open, m_has, m_phs, m_pvs, m_L, m_C;
  logic [DW-1:0] img [64][16];

  int lp [16];   // pixel values of the last driven line
  int li [16];   // tick index of each pixel of the last driven line

  task automatic tick(input int r, input int v, input int h, input int d,
                      input int p, input int a, input int w);
    rec_t e;
    int   hr, vr;
    rst   = (r != 0);
    vsync = (v != 0);
    hsync = (h != 0);
    de    = (d != 0);
    pix   = DW'(p);
    addr  = AW'(a);
    width = AW'(w);
    e = '0;
    if (r != 0) begin
      m_open = 0; m_has = 0; m_phs = 0; m_pvs = 0; m_L = 0; m_C = 0;
    end else begin
      hr = (h != 0 && m_phs == 0) ? 1 : 0;
      vr = (v != 0 && m_pvs == 0) ? 1 : 0;
      if (hr != 0) begin
        if (m_has != 0) m_L++;
        m_has = 0; m_C = 0; m_open = 1;
      end
      if (vr != 0) begin
        m_L = 0;
        if (hr == 0) begin m_open = 0; m_has = 0; end
      end
      e.de  = (d != 0);
      e.hs  = (h != 0);
      e.vs  = (v != 0);
      e.eol = (d != 0) && (w != 0) && (a == w - 1);
      if (d != 0) begin
        if (m_open != 0) begin
          if (m_C < 16) img[m_L % 64][m_C] = DW'(p);
          m_has = 1;
          if (m_L >= 2 && m_C >= 2 && m_C < 16) begin
            e.valid = 1'b1;
            for (int rr = 0; rr < 3; rr++)
              for (int cc = 0; cc < 3; cc++)
                e.win[(rr*3+cc)*DW +: DW] = img[(m_L-2+rr) % 64][m_C-2+cc];
          end
        end
        m_C++;
      end
      m_phs = h; m_pvs = v;
    end
    exp_q.push_back(e);
    rst_q.push_back(r);
    @(posedge clk);
    #1;
    act_q.push_back({win_valid, de_o, hs_o, vs_o, eol_o, win});
  endtask

  // Expected content of act_q[k]: input of tick k-1, wiped by a reset in tick k-1 or k
  function automatic rec_t exp_at(input int k);
    rec_t z;
    z = '0;
    if (k < 1) return z;
    if (rst_q[k-1] != 0 || rst_q[k] != 0) return z;
    return exp_q[k-1];
  endfunction

  task automatic idle(input int n, input int w);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, w);
  endtask

  task automatic vs_pulse(input int w);
    tick(0, 1, 0, 0, 0, 0, w);
    tick(0, 0, 0, 0, 0, 0, w);
  endtask

  task automatic drive_line(input int ln, input int npix, input int rnd,
                            input int gap_max, input int w);
    tick(0, 0, 1, 0, 0, 0, w);
    tick(0, 0, 0, 0, 0, 0, w);
    for (int c = 0; c < npix; c++) begin
      int g;
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      for (int j = 0; j < g; j++) tick(0, 0, 0, 0, 0, 0, w);
      lp[c] = (rnd != 0) ? int'($urandom_range(255, 0)) : (16 * ln + c) % 256;
      li[c] = exp_q.size();
      tick(0, 0, 0, 1, lp[c], c, w);
    end
    idle(2, w);
  endtask

  task automatic test_reset();
    int   base;
    rec_t a;
    base = act_q.size();
    for (int i = 0; i < 3; i++)
      tick(1, int'($urandom_range(1, 0)), int'($urandom_range(1, 0)), int'($urandom_range(1, 0)),
           int'($urandom_range(255, 0)), int'($urandom_range(2047, 0)), int'($urandom_range(2047, 0)));
    idle(10, 4);
    for (int k = base; k < act_q.size(); k++) begin
      a = act_q[k];
      n_tests++;
      if (a !== rec_t'(0)) begin
        n_fail++;
        $display("FAIL reset cyc%0d: got v%b de%b hs%b vs%b eol%b win=%h, expected all zero",
                 k, a.valid, a.de, a.hs, a.vs, a.eol, a.win);
      end
    end
  endtask

  task automatic test_basic();
    int   base, first, nvalid;
    rec_t a, e;
    base = act_q.size();
    vs_pulse(4);
    drive_line(0, 4, 0, 0, 4);
    drive_line(1, 4, 0, 0, 4);
    drive_line(2, 4, 0, 0, 4);
    first = -1; nvalid = 0;
    for (int k = base; k < act_q.size(); k++) begin
      if (act_q[k].valid === 1'b1) begin
        nvalid++;
        if (first < 0) first = k;
      end
    end
    n_tests++;
    if (first != li[2] + 1) begin
      n_fail++; $display("FAIL basic_first_valid: got cyc%0d, expected cyc%0d", first, li[2] + 1);
    end else begin
      n_tests++;
      if (act_q[first].win !== 72'h22_21_20_12_11_10_02_01_00) begin
        n_fail++; $display("FAIL basic_win: got %h, expected 222120121110020100", act_q[first].win);
      end
    end
    n_tests++;
    if (nvalid != 2) begin
      n_fail++; $display("FAIL basic_nvalid: got %0d, expected 2", nvalid);
    end
    n_tests++;
    if (act_q[li[3]+1].eol !== 1'b1 || act_q[li[3]+1].valid !== 1'b1) begin
      n_fail++; $display("FAIL basic_eol: got eol%b v%b, expected eol1 v1",
                         act_q[li[3]+1].eol, act_q[li[3]+1].valid);
    end
    for (int k = base; k < act_q.size(); k++) begin
      e = exp_at(k); a = act_q[k];
      n_tests++;
      if (a.valid !== e.valid || a.de !== e.de || a.hs !== e.hs || a.vs !== e.vs ||
          a.eol !== e.eol || (e.valid && a.win !== e.win)) begin
        n_fail++;
        $display("FAIL basic cyc%0d: got v%b de%b hs%b vs%b eol%b win=%h, expected v%b de%b hs%b vs%b eol%b win=%h",
                 k, a.valid, a.de, a.hs, a.vs, a.eol, a.win, e.valid, e.de, e.hs, e.vs, e.eol, e.win);
      end
    end
  endtask

  task automatic test_empty_line();
    int   base, first, nvalid;
    rec_t a, e;
    base = act_q.size();
    vs_pulse(4);
    drive_line(0, 4, 0, 0, 4);
    tick(0, 0, 1, 0, 0, 0, 4);
    idle(6, 4);
    drive_line(1, 4, 0, 0, 4);
    drive_line(2, 4, 0, 0, 4);
    first = -1; nvalid = 0;
    for (int k = base; k < act_q.size(); k++) begin
      if (act_q[k].valid === 1'b1) begin
        nvalid++;
        if (first < 0) first = k;
      end
    end
    n_tests++;
    if (first != li[2] + 1 || nvalid != 2) begin
      n_fail++; $display("FAIL empty_line_valid: got first cyc%0d count %0d, expected cyc%0d count 2",
                         first, nvalid, li[2] + 1);
    end else begin
      n_tests++;
      if (act_q[first].win !== 72'h22_21_20_12_11_10_02_01_00) begin
        n_fail++; $display("FAIL empty_line_win: got %h, expected 222120121110020100", act_q[first].win);
      end
    end
    for (int k = base; k < act_q.size(); k++) begin
      e = exp_at(k); a = act_q[k];
      n_tests++;
      if (a.valid !== e.valid || a.de !== e.de || a.hs !== e.hs || a.vs !== e.vs ||
          a.eol !== e.eol || (e.valid && a.win !== e.win)) begin
        n_fail++;
        $display("FAIL empty_line cyc%0d: got v%b de%b hs%b vs%b eol%b win=%h, expected v%b de%b hs%b vs%b eol%b win=%h",
                 k, a.valid, a.de, a.hs, a.vs, a.eol, a.win, e.valid, e.de, e.hs, e.vs, e.eol, e.win);
      end
    end
  endtask

  task automatic test_mid_vsync();
    int            base, vsi, first, nvalid;
    logic [23:0]   top_a;
    rec_t          a, e;
    base = act_q.size();
    vs_pulse(4);
    for (int l = 0; l < 3; l++) drive_line(l, 4, 1, 0, 4);
    // line 3 with vsync arriving alongside its second pixel
    tick(0, 0, 1, 0, 0, 0, 4);
    tick(0, 0, 0, 0, 0, 0, 4);
    tick(0, 0, 0, 1, int'($urandom_range(255, 0)), 0, 4);
    vsi = exp_q.size();
    tick(0, 1, 0, 1, int'($urandom_range(255, 0)), 1, 4);
    tick(0, 0, 0, 1, int'($urandom_range(255, 0)), 2, 4);
    tick(0, 0, 0, 1, int'($urandom_range(255, 0)), 3, 4);
    idle(2, 4);
    drive_line(0, 4, 1, 0, 4);
    top_a = {lp[2][7:0], lp[1][7:0], lp[0][7:0]};
    drive_line(1, 4, 1, 0, 4);
    drive_line(2, 4, 1, 0, 4);
    first = -1; nvalid = 0;
    for (int k = vsi + 1; k < act_q.size(); k++) begin
      if (act_q[k].valid === 1'b1) begin
        nvalid++;
        if (first < 0) first = k;
      end
    end
    n_tests++;
    if (first != li[2] + 1 || nvalid != 2) begin
      n_fail++; $display("FAIL mid_vsync_valid: got first cyc%0d count %0d, expected cyc%0d count 2",
                         first, nvalid, li[2] + 1);
    end else begin
      n_tests++;
      if (act_q[first].win[23:0] !== top_a) begin
        n_fail++; $display("FAIL mid_vsync_top_row: got %h, expected %h", act_q[first].win[23:0], top_a);
      end
    end
    for (int k = base; k < act_q.size(); k++) begin
      e = exp_at(k); a = act_q[k];
      n_tests++;
      if (a.valid !== e.valid || a.de !== e.de || a.hs !== e.hs || a.vs !== e.vs ||
          a.eol !== e.eol || (e.valid && a.win !== e.win)) begin
        n_fail++;
        $display("FAIL mid_vsync cyc%0d: got v%b de%b hs%b vs%b eol%b win=%h, expected v%b de%b hs%b vs%b eol%b win=%h",
                 k, a.valid, a.de, a.hs, a.vs, a.eol, a.win, e.valid, e.de, e.hs, e.vs, e.eol, e.win);
      end
    end
  endtask

  task automatic test_de_gaps();
    int   base, first, bad;
    rec_t a, e;
    base = act_q.size();
    vs_pulse(4);
    for (int l = 0; l < 3; l++) drive_line(l, 4, 0, 3, 4);
    first = -1; bad = 0;
    for (int k = base; k < act_q.size(); k++)
      if (act_q[k].valid === 1'b1 && first < 0) first = k;
    n_tests++;
    if (first != li[2] + 1) begin
      n_fail++; $display("FAIL gaps_first_valid: got cyc%0d, expected cyc%0d", first, li[2] + 1);
    end else begin
      n_tests++;
      if (act_q[first].win !== 72'h22_21_20_12_11_10_02_01_00) begin
        n_fail++; $display("FAIL gaps_win: got %h, expected 222120121110020100", act_q[first].win);
      end
    end
    for (int l = 3; l < 6; l++) drive_line(l, 4, 1, 3, 4);
    for (int k = base; k < act_q.size(); k++)
      if (act_q[k].valid === 1'b1 && act_q[k].de !== 1'b1) bad++;
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL gaps_valid_without_de: got %0d cycles, expected 0", bad);
    end
    for (int k = base; k < act_q.size(); k++) begin
      e = exp_at(k); a = act_q[k];
      n_tests++;
      if (a.valid !== e.valid || a.de !== e.de || a.hs !== e.hs || a.vs !== e.vs ||
          a.eol !== e.eol || (e.valid && a.win !== e.win)) begin
        n_fail++;
        $display("FAIL de_gaps cyc%0d: got v%b de%b hs%b vs%b eol%b win=%h, expected v%b de%b hs%b vs%b eol%b win=%h",
                 k, a.valid, a.de, a.hs, a.vs, a.eol, a.win, e.valid, e.de, e.hs, e.vs, e.eol, e.win);
      end
    end
  endtask

  task automatic test_mid_reset();
    int   base, ri, first, nvalid;
    rec_t a, e;
    base = act_q.size();
    vs_pulse(4);
    drive_line(0, 4, 1, 0, 4);
    drive_line(1, 4, 1, 0, 4);
    tick(0, 0, 1, 0, 0, 0, 4);
    tick(0, 0, 0, 0, 0, 0, 4);
    tick(0, 0, 0, 1, int'($urandom_range(255, 0)), 0, 4);
    tick(0, 0, 0, 1, int'($urandom_range(255, 0)), 1, 4);
    ri = exp_q.size();
    tick(1, 0, 0, 1, int'($urandom_range(255, 0)), 2, 4);
    tick(0, 0, 0, 1, int'($urandom_range(255, 0)), 3, 4);
    idle(2, 4);
    n_tests++;
    if (act_q[ri].valid !== 1'b0 || act_q[ri].de !== 1'b0 || act_q[ri+1].valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_drop: got v%b de%b then v%b, expected v0 de0 then v0",
                         act_q[ri].valid, act_q[ri].de, act_q[ri+1].valid);
    end
    for (int l = 0; l < 3; l++) drive_line(l, 4, 1, 0, 4);
    first = -1; nvalid = 0;
    for (int k = ri; k < act_q.size(); k++) begin
      if (act_q[k].valid === 1'b1) begin
        nvalid++;
        if (first < 0) first = k;
      end
    end
    n_tests++;
    if (first != li[2] + 1 || nvalid != 2) begin
      n_fail++; $display("FAIL mid_reset_recovery: got first cyc%0d count %0d, expected cyc%0d count 2",
                         first, nvalid, li[2] + 1);
    end
    for (int k = base; k < act_q.size(); k++) begin
      e = exp_at(k); a = act_q[k];
      n_tests++;
      if (a.valid !== e.valid || a.de !== e.de || a.hs !== e.hs || a.vs !== e.vs ||
          a.eol !== e.eol || (e.valid && a.win !== e.win)) begin
        n_fail++;
        $display("FAIL mid_reset cyc%0d: got v%b de%b hs%b vs%b eol%b win=%h, expected v%b de%b hs%b vs%b eol%b win=%h",
                 k, a.valid, a.de, a.hs, a.vs, a.eol, a.win, e.valid, e.de, e.hs, e.vs, e.eol, e.win);
      end
    end
  endtask

  task automatic test_width_zero();
    int   base, neol, nvalid;
    rec_t a, e;
    base = act_q.size();
    vs_pulse(0);
    for (int l = 0; l < 3; l++) drive_line(l, 4, 1, 1, 0);
    neol = 0; nvalid = 0;
    for (int k = base; k < act_q.size(); k++) begin
      if (act_q[k].eol !== 1'b0) neol++;
      if (act_q[k].valid === 1'b1) nvalid++;
    end
    n_tests++;
    if (neol != 0 || nvalid != 2) begin
      n_fail++; $display("FAIL width_zero: got eol count %0d valid count %0d, expected 0 and 2", neol, nvalid);
    end
    for (int k = base; k < act_q.size(); k++) begin
      e = exp_at(k); a = act_q[k];
      n_tests++;
      if (a.valid !== e.valid || a.de !== e.de || a.hs !== e.hs || a.vs !== e.vs ||
          a.eol !== e.eol || (e.valid && a.win !== e.win)) begin
        n_fail++;
        $display("FAIL width_zero cyc%0d: got v%b de%b hs%b vs%b eol%b win=%h, expected v%b de%b hs%b vs%b eol%b win=%h",
                 k, a.valid, a.de, a.hs, a.vs, a.eol, a.win, e.valid, e.de, e.hs, e.vs, e.eol, e.win);
      end
    end
  endtask

  initial begin
    rst = 1'b1; vsync = 1'b0; hsync = 1'b0; de = 1'b0;
    pix = '0; addr = '0; width = '0;
    m_open = 0; m_has = 0; m_phs = 0; m_pvs = 0; m_L = 0; m_C = 0;
    test_reset();
    test_basic();
    test_empty_line();
    test_mid_vsync();
    test_de_gaps();
    test_mid_reset();
    test_width_zero();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
